// File: rtl/operand_fetch_ctrl.sv
// Streams packed double-precision operand pairs from a combinational data memory
// to an FPU with a valid/ready handshake, one pair per cycle when unstalled.
module operand_fetch_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_pairs,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [63:0]       op_a,
    output logic [63:0]       op_b,
    output logic [ADDR_W-1:0] op_tag,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t            state_r;
    logic [ADDR_W:0]   remaining_r;
    logic              handshake_s;
    logic [ADDR_W-1:0] addr_next_s;

    // Handshake and wrapping next-address decode.
    always_comb begin
        handshake_s = op_valid & op_ready;
        addr_next_s = mem_addr + ADDR_W'(1);
    end

    // Run FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            remaining_r <= {(ADDR_W+1){1'b0}};
            mem_addr    <= {ADDR_W{1'b0}};
            op_a        <= 64'd0;
            op_b        <= 64'd0;
            op_tag      <= {ADDR_W{1'b0}};
            op_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && (num_pairs != {(ADDR_W+1){1'b0}})) begin
                        mem_addr    <= base_addr;
                        remaining_r <= num_pairs;
                        busy        <= 1'b1;
                        state_r     <= FETCH;
                    end else if (start) begin
                        done <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        op_valid <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        op_a        <= mem_data[DATA_W-1 -: 64];
                        op_b        <= mem_data[63:0];
                        op_tag      <= mem_addr;
                        op_valid    <= 1'b1;
                        mem_addr    <= addr_next_s;
                        remaining_r <= remaining_r - (ADDR_W+1)'(1);
                        state_r     <= STREAM;
                    end
                end
                STREAM: begin
                    // Abort wins over a handshake in the same cycle.
                    if (abort) begin
                        op_valid <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end else if (handshake_s && (remaining_r != {(ADDR_W+1){1'b0}})) begin
                        op_a        <= mem_data[DATA_W-1 -: 64];
                        op_b        <= mem_data[63:0];
                        op_tag      <= mem_addr;
                        mem_addr    <= addr_next_s;
                        remaining_r <= remaining_r - (ADDR_W+1)'(1);
                    end else if (handshake_s) begin
                        op_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= STREAM;
                    end
                end
                default: begin
                    op_valid <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed bench for operand_fetch_ctrl: a combinational memory model feeds the
// DUT and each observation is checked against hand-computed values.
module tb_operand_fetch_ctrl;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 128;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_pairs;
    logic              abort;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [63:0]       op_a;
    logic [63:0]       op_b;
    logic [ADDR_W-1:0] op_tag;
    logic              op_valid;
    logic              op_ready;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks;
    int n_fails;

    operand_fetch_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_pairs (num_pairs),
        .abort     (abort),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_tag    (op_tag),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pair(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [12:0] t);
        chk({tag, "_valid"}, 128'(op_valid), 128'd1);
        chk({tag, "_a"}, 128'(op_a), 128'(a));
        chk({tag, "_b"}, 128'(op_b), 128'(b));
        chk({tag, "_tag"}, 128'(op_tag), 128'(t));
    endtask

    task automatic begin_run(input logic [12:0] b, input logic [13:0] n);
        start     = 1'b1;
        base_addr = b;
        num_pairs = n;
        tick();
        start     = 1'b0;
    endtask

    // Full base=8 num=3 run with op_ready held high.
    task automatic run_basic(input string tag);
        op_ready = 1'b1;
        begin_run(13'd8, 14'd3);
        chk({tag, "_addr_n1"}, 128'(mem_addr), 128'd8);
        chk({tag, "_valid_n1"}, 128'(op_valid), 128'd0);
        chk({tag, "_busy_n1"}, 128'(busy), 128'd1);
        tick();
        chk_pair({tag, "_p0"}, 64'h3FF0000000000000, 64'h4000000000000000, 13'd8);
        tick();
        chk_pair({tag, "_p1"}, 64'h4020000000000000, 64'h4030000000000000, 13'd9);
        chk({tag, "_done_mid"}, 128'(done), 128'd0);
        tick();
        chk_pair({tag, "_p2"}, 64'h3FD999999999999A, 64'h3FE0000000000000, 13'd10);
        tick();
        chk({tag, "_done"}, 128'(done), 128'd1);
        chk({tag, "_valid_end"}, 128'(op_valid), 128'd0);
        chk({tag, "_busy_end"}, 128'(busy), 128'd0);
        tick();
        chk({tag, "_done_pulse"}, 128'(done), 128'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 13'd0;
        num_pairs = 14'd0;
        abort     = 1'b0;
        op_ready  = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 128'd0;
        mem[0]    = {64'h4060000000000000, 64'h8000000000000000};
        mem[1]    = {64'h405EDD2F1A9FBE77, 64'hC05EDD2F1A9FBE77};
        mem[8]    = {64'h3FF0000000000000, 64'h4000000000000000};
        mem[9]    = {64'h4020000000000000, 64'h4030000000000000};
        mem[10]   = {64'h3FD999999999999A, 64'h3FE0000000000000};
        mem[20]   = {64'h0000000000000001, 64'h800FFFFFFFFFFFFF};
        mem[21]   = {64'h7FF8000000000001, 64'hFFF0000000000000};
        mem[8191] = {64'h7FF0000000000000, 64'h7FF8000000000000};

        tick();
        tick();
        chk("rst_addr", 128'(mem_addr), 128'd0);
        chk("rst_valid", 128'(op_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_opa", 128'(op_a), 128'd0);
        rst = 1'b0;
        tick();

        run_basic("basic");

        // Stall: ready low for four cycles, with an ignored start mid-run.
        op_ready = 1'b0;
        begin_run(13'd0, 14'd2);
        tick();
        chk_pair("stall_p0", 64'h4060000000000000, 64'h8000000000000000, 13'd0);
        for (int i = 0; i < 4; i++) begin
            start     = (i == 1);
            base_addr = 13'd100;
            num_pairs = 14'd7;
            tick();
            chk("stall_opa", 128'(op_a), 128'h4060000000000000);
            chk("stall_tag", 128'(op_tag), 128'd0);
            chk("stall_addr", 128'(mem_addr), 128'd1);
            chk("stall_valid", 128'(op_valid), 128'd1);
        end
        start    = 1'b0;
        op_ready = 1'b1;
        tick();
        chk_pair("stall_p1", 64'h405EDD2F1A9FBE77, 64'hC05EDD2F1A9FBE77, 13'd1);
        chk("stall_done_mid", 128'(done), 128'd0);
        tick();
        chk("stall_done", 128'(done), 128'd1);
        chk("stall_valid_end", 128'(op_valid), 128'd0);
        tick();
        chk("stall_done_once", 128'(done), 128'd0);

        // Address wrap 8191 -> 0.
        begin_run(13'd8191, 14'd2);
        tick();
        chk_pair("wrap_p0", 64'h7FF0000000000000, 64'h7FF8000000000000, 13'd8191);
        chk("wrap_addr", 128'(mem_addr), 128'd0);
        tick();
        chk_pair("wrap_p1", 64'h4060000000000000, 64'h8000000000000000, 13'd0);
        tick();
        chk("wrap_done", 128'(done), 128'd1);
        tick();

        // Zero-length run.
        begin_run(13'd5, 14'd0);
        chk("zero_done", 128'(done), 128'd1);
        chk("zero_busy", 128'(busy), 128'd0);
        chk("zero_valid", 128'(op_valid), 128'd0);
        tick();
        chk("zero_done_once", 128'(done), 128'd0);
        chk("zero_valid2", 128'(op_valid), 128'd0);

        // Abort while idle has no effect.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 128'(busy), 128'd0);
        chk("idle_abort_done", 128'(done), 128'd0);

        // Abort right after the first handshake of a 5-pair run.
        op_ready = 1'b1;
        begin_run(13'd20, 14'd5);
        tick();
        chk_pair("abort_p0", 64'h0000000000000001, 64'h800FFFFFFFFFFFFF, 13'd20);
        tick();
        chk_pair("abort_p1", 64'h7FF8000000000001, 64'hFFF0000000000000, 13'd21);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 128'(op_valid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 128'(done), 128'd0);
            chk("abort_idle_valid", 128'(op_valid), 128'd0);
        end
        run_basic("after_abort");

        // Asynchronous reset in the middle of streaming.
        op_ready = 1'b0;
        begin_run(13'd8, 14'd3);
        tick();
        chk("prerst_valid", 128'(op_valid), 128'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 128'(op_valid), 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_opa", 128'(op_a), 128'd0);
        chk("arst_opb", 128'(op_b), 128'd0);
        chk("arst_tag", 128'(op_tag), 128'd0);
        chk("arst_addr", 128'(mem_addr), 128'd0);
        chk("arst_done", 128'(done), 128'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_valid", 128'(op_valid), 128'd0);
        chk("postrst_busy", 128'(busy), 128'd0);
        run_basic("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
